gcd_sequencer: RTL
==================

Name: gcd_sequencer

Overview:
- FSM controller that drives the Euclid GCD datapath (modulo ALU, write-back flags, operand routing) through one complete computation per command.
- Accepts a command handshake and sequences load, modulo, write-back, termination check and operand shift until the datapath reports a zero remainder.
- Bounds the loop with an iteration limit and a modulo-wait timeout, and reports done/error status to the system side.

Parameters:
- MAX_ITER, 24: maximum modulo iterations before the command aborts with error (24 covers the 16-bit Fibonacci worst case of 23).
- WAIT_TIMEOUT, 64: maximum cycles spent waiting for modulo_ready_i per iteration.
- ITER_W, 5: width of the iteration counter; must satisfy 2^ITER_W > MAX_ITER.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  request to start a GCD; operands are already on the datapath number inputs
- cmd_ready_o  out  1  high only in IDLE
- done_o  out  1  one-cycle pulse when the result is valid on the datapath result bus
- err_o  out  1  one-cycle pulse, concurrent with done_o, on abort
- err_code_o  out  2  0 = none, 1 = iteration limit, 2 = modulo timeout; held until the next accepted command
- iter_count_o  out  ITER_W  iterations completed by the last or current command
- busy_o  out  1  high whenever state != IDLE
- dp_start_o  out  1  datapath operand-load strobe
- alu_mode_o  out  3  ALU operation select
- modulo_start_o  out  1  one-cycle modulo launch pulse
- modulo_ready_i  in  1  modulo unit finished
- valid_i  in  1  datapath termination flag (zero remainder while check is asserted)
- check_for_termination_o  out  1  enables the datapath termination compare
- wren_erg_modulo_o, wren_zahl_o, wren_to_new_numbers_o  out  1 each  write-back strobes
- zahl1_to_alu_a_o, zahl2_to_alu_b_o  out  1 each  operand routing to the ALU

Behaviour:
- Reset: state IDLE, all outputs 0 except cmd_ready_o = 1; counters 0; err_code_o = 0. Reset applies mid-operation with no cleanup cycle.
- Outputs are registered Moore outputs decoded from the next state, so strobes are aligned with the state they belong to.
- At most one wren_* strobe is high in any cycle. zahl1_to_alu_a_o and zahl2_to_alu_b_o are high, and alu_mode_o = ALU_MODE_MOD, from MOD_START through MOD_WAIT; otherwise alu_mode_o = ALU_MODE_NOP.
- IDLE: when cmd_valid_i = 1, clear iter_count_o and err_code_o, then go to LOAD.
- LOAD (2 cycles): dp_start_o high both cycles, covering the datapath's one-cycle input register, then go to MOD_START.
- MOD_START (1 cycle): modulo_start_o = 1; clear the wait counter.
- MOD_WAIT: increment the wait counter each cycle.
  - If modulo_ready_i = 1, go to MOD_LATCH.
  - Else, when the wait counter reaches WAIT_TIMEOUT-1, set err_code 2 and go to DONE.
  - modulo_ready_i on the same cycle as the timeout: ready wins.
- MOD_LATCH (1 cycle): lets the ALU output register capture the result.
- WB_MOD (1 cycle): wren_erg_modulo_o = 1; iter_count increments.
- CHECK (1 cycle): check_for_termination_o = 1.
  - If valid_i = 1, go to DONE (no error).
  - Else, if iter_count == MAX_ITER, set err_code 1 and go to DONE.
  - Else go to SHIFT_A.
- SHIFT_A (1 cycle): wren_zahl_o = 1 (A <= B).
- SHIFT_B (1 cycle): wren_to_new_numbers_o = 1 (B <= remainder), then go to MOD_START.
- DONE (1 cycle): done_o = 1; err_o = (err_code != 0); return to IDLE.
- cmd_valid_i while busy_o = 1 is ignored; there is no queuing.
- Cycle count: one iteration is 6 + modulo latency cycles; a command costs 2 + iterations × (6 + latency) + 1 − 2 (the final iteration skips the shift states).
- iter_count saturates at MAX_ITER and never wraps.

Decomposition:
- gcd_pkg: state encoding localparams, ALU_MODE_MOD = 3'd4, ALU_MODE_NOP = 3'd0, and the ERR_NONE, ERR_ITER and ERR_TIMEOUT codes.
- One sub-module, gcd_seq_timer: wait counter with clear, enable and terminal-count output, reused for the timeout.
- All other logic stays in the single FSM.

Test Plan:
- 48, 18 with a 4-cycle modulo stub wired to the real datapath -> done_o after 3 iterations, result 6, err_o = 0, iter_count_o = 3, exactly one done_o pulse.
- 17, 5 (coprime) -> result 1, iter_count_o = 3, and the strobe sequence per iteration matches MOD_START..SHIFT_B with no two wren_* high together.
- Stub never asserts modulo_ready_i -> err_o and done_o high together exactly 64 cycles after modulo_start_o, err_code_o = 2, then cmd_ready_o returns to 1.
- MAX_ITER = 2 with 46368, 28657 -> abort after iteration 2, err_code_o = 1, iter_count_o = 2.
- cmd_valid_i pulsed mid-computation, then rst asserted during MOD_WAIT -> the first pulse is ignored; the cycle after reset all strobes are 0, cmd_ready_o = 1 and err_code_o = 0.
- modulo_ready_i on the same cycle the timeout expires -> proceeds to MOD_LATCH with no error.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding, ALU modes and error codes for the GCD sequencer
package gcd_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD1, S_LOAD2, S_MOD_START, S_MOD_WAIT, S_MOD_LATCH,
    S_WB_MOD, S_CHECK, S_SHIFT_A, S_SHIFT_B, S_DONE
  } state_t;
  localparam logic [2:0] ALU_MODE_NOP = 3'd0;
  localparam logic [2:0] ALU_MODE_MOD = 3'd4;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ITER = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
endpackage

// File: rtl/gcd_seq_timer.sv
// gcd_seq_timer: wait counter with clear/enable; tc marks the enabled cycle whose increment reaches LIMIT-1
// Ports: clk, rst; clr zeroes the count; en counts one cycle; tc terminal-count flag.
module gcd_seq_timer #(
  parameter int LIMIT = 64,
  parameter int W = $clog2(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [W-1:0] LAST = W'(LIMIT - 2);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    count <= (rst || clr) ? '0 : en ? count + W'(1) : count;
  assign tc = en && count == LAST;
endmodule

// File: rtl/gcd_sequencer.sv
// gcd_sequencer: Euclid GCD datapath controller with iteration limit and modulo-wait timeout
// Ports: cmd_valid_i/cmd_ready_o handshake; done_o, err_o, err_code_o, iter_count_o, busy_o status;
//        dp_start_o, alu_mode_o, modulo_start_o, check/wren/routing strobes to the datapath;
//        modulo_ready_i and valid_i feedback from the datapath.
module gcd_sequencer
  import gcd_pkg::*;
#(
  parameter int MAX_ITER = 24,
  parameter int WAIT_TIMEOUT = 64,
  parameter int ITER_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [ITER_W-1:0] iter_count_o,
  output logic              busy_o,
  output logic              dp_start_o,
  output logic [2:0]        alu_mode_o,
  output logic              modulo_start_o,
  input  logic              modulo_ready_i,
  input  logic              valid_i,
  output logic              check_for_termination_o,
  output logic              wren_erg_modulo_o,
  output logic              wren_zahl_o,
  output logic              wren_to_new_numbers_o,
  output logic              zahl1_to_alu_a_o,
  output logic              zahl2_to_alu_b_o
);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);
  state_t state, state_next;
  logic [ITER_W-1:0] iter, iter_next;
  logic [1:0] err, err_next;
  logic timeout, route_next;
  gcd_seq_timer #(.LIMIT(WAIT_TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state == S_MOD_START),
    .en(state == S_MOD_WAIT),
    .tc(timeout)
  );
  always_comb begin
    state_next = state;
    iter_next = iter;
    err_next = err;
    case (state)
      S_IDLE: if (cmd_valid_i) begin
        state_next = S_LOAD1;
        iter_next = '0;
        err_next = ERR_NONE;
      end
      S_LOAD1: state_next = S_LOAD2;
      S_LOAD2: state_next = S_MOD_START;
      S_MOD_START: state_next = S_MOD_WAIT;
      S_MOD_WAIT: if (modulo_ready_i) state_next = S_MOD_LATCH;
        else if (timeout) begin
          state_next = S_DONE;
          err_next = ERR_TIMEOUT;
        end
      S_MOD_LATCH: state_next = S_WB_MOD;
      S_WB_MOD: begin
        state_next = S_CHECK;
        iter_next = (iter == ITER_MAX) ? iter : iter + ITER_W'(1);
      end
      S_CHECK: if (valid_i) state_next = S_DONE;
        else if (iter == ITER_MAX) begin
          state_next = S_DONE;
          err_next = ERR_ITER;
        end else state_next = S_SHIFT_A;
      S_SHIFT_A: state_next = S_SHIFT_B;
      S_SHIFT_B: state_next = S_MOD_START;
      default: state_next = S_IDLE;
    endcase
  end
  assign route_next = state_next == S_MOD_START || state_next == S_MOD_WAIT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      iter <= '0;
      err <= ERR_NONE;
      cmd_ready_o <= 1'b1;
      {done_o, err_o, busy_o, dp_start_o, modulo_start_o, check_for_termination_o} <= '0;
      {wren_erg_modulo_o, wren_zahl_o, wren_to_new_numbers_o, zahl1_to_alu_a_o, zahl2_to_alu_b_o} <= '0;
      alu_mode_o <= ALU_MODE_NOP;
    end else begin
      state <= state_next;
      iter <= iter_next;
      err <= err_next;
      cmd_ready_o <= state_next == S_IDLE;
      busy_o <= state_next != S_IDLE;
      done_o <= state_next == S_DONE;
      err_o <= state_next == S_DONE && err_next != ERR_NONE;
      dp_start_o <= state_next == S_LOAD1 || state_next == S_LOAD2;
      modulo_start_o <= state_next == S_MOD_START;
      check_for_termination_o <= state_next == S_CHECK;
      wren_erg_modulo_o <= state_next == S_WB_MOD;
      wren_zahl_o <= state_next == S_SHIFT_A;
      wren_to_new_numbers_o <= state_next == S_SHIFT_B;
      zahl1_to_alu_a_o <= route_next;
      zahl2_to_alu_b_o <= route_next;
      alu_mode_o <= route_next ? ALU_MODE_MOD : ALU_MODE_NOP;
    end
  end
  assign iter_count_o = iter;
  assign err_code_o = err;
endmodule
